// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in / parallel-out deserializer with a valid/ready output register.
//   Bits arrive LSB first on sin, qualified by sin_en. Each completed frame is
//   loaded into data_out, unless an unconsumed word is still pending there.
//   In that case the new word is dropped and the sticky overrun flag is set.
//
//   Build option:
//     DESER_PARITY_EN  - when defined, a frame has 9 bits. The 9th bit is even
//                        parity over the 8 data bits. The parity_err port
//                        reports a mismatch for the word on data_out.
//                        When undefined, a frame has 8 bits and parity_err
//                        does not exist.
//
//   Ports:
//     clk        - single clock, rising edge
//     rst        - asynchronous reset, active low
//     sin        - serial data bit (word LSB first)
//     sin_en     - qualifies sin for this cycle
//     sync       - frame-align pulse; restarts bit collection
//     data_out   - received word, held while out_valid=1
//     out_valid  - data_out holds an unconsumed word
//     out_ready  - consumer accepts data_out when out_valid=1
//     overrun    - sticky: a completed word was dropped
//     clr_ovr    - synchronous clear of overrun (a new overrun event wins)
//     parity_err - parity mismatch on data_out (DESER_PARITY_EN only)
// -----------------------------------------------------------------------------
module sipo_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sin_en,
  input  logic       sync,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clr_ovr
`ifdef DESER_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } state_e;

  // Index of the last bit of a frame, counted from 0.
`ifdef DESER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [7:0] data_q,  data_d;
  logic       valid_q, valid_d;
  logic       ovr_q,   ovr_d;
`ifdef DESER_PARITY_EN
  logic       perr_q,  perr_d;
  logic       word_perr;
`endif

  state_e     state;
  logic [3:0] cnt_base;
  logic [7:0] word;
  logic       ovr_set;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: bit collection
  // ---------------------------------------------------------------------------
  // COMPLETE is a decode of the current cycle. It is not a registered state:
  // the word must load on the same edge that samples its last bit. sync
  // restarts the count from 0 for this cycle. A bit qualified together with
  // sync therefore becomes bit 0 of the new frame.
  always_comb begin
    cnt_base = sync ? 4'd0 : cnt_q;
    cnt_d    = cnt_base;
    shift_d  = shift_q;
    state    = COLLECT;
    word     = {sin, shift_q[7:1]};
`ifdef DESER_PARITY_EN
    word_perr = 1'b0;
`endif

    if (sin_en) begin
      if (cnt_base == LAST_BIT) begin
        state = COMPLETE;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_base + 4'd1;
      end

`ifdef DESER_PARITY_EN
      // The parity bit is not shifted in. The data bits already fill the
      // register, and the parity bit is checked against them directly.
      if (cnt_base == LAST_BIT) begin
        word      = shift_q;
        word_perr = ^{shift_q, sin};
      end else begin
        shift_d = {sin, shift_q[7:1]};
      end
`else
      shift_d = {sin, shift_q[7:1]};
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: output register, handshake, overrun
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
`ifdef DESER_PARITY_EN
    perr_d  = perr_q;
`endif

    if (state == COMPLETE) begin
      // The slot is free if it is empty, or if its word is consumed this cycle.
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef DESER_PARITY_EN
        perr_d  = word_perr;
`endif
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
  end

  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign overrun    = ovr_q;
`ifdef DESER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin, sin_en, sync, out_ready, clr_ovr;
  logic [7:0] data_out;
  logic       out_valid, overrun;
`ifdef DESER_PARITY_EN
  logic       parity_err;
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  always #5 clk = ~clk;

  sipo_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .sync      (sync),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
`ifdef DESER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_on = 1'b0;

  // Reference model state: the bits of the frame in progress, the words
  // expected on data_out (oldest first, {parity_err, data}), and the expected
  // out_valid and overrun values.
  logic [8:0] sb_q[$];
  bit         bits[$];
  logic       exp_valid = 1'b0;
  logic       exp_ovr   = 1'b0;

  function automatic void chk(string nm, logic [8:0] act, logic [8:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // Drive one cycle of inputs and predict the result from the behavioural rules.
  task automatic cycle(input logic s, input logic en, input logic sy,
                       input logic rdy, input logic clr);
    logic       comp, drop, pe, nv, no;
    logic [7:0] w;
    sin = s; sin_en = en; sync = sy; out_ready = rdy; clr_ovr = clr;
    comp = 1'b0; drop = 1'b0; pe = 1'b0; w = '0;
    if (sy) bits.delete();
    if (en) begin
      bits.push_back(s);
      if (bits.size() == FRAME) begin
        comp = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = bits[i];
`ifdef DESER_PARITY_EN
        pe = ((($countones(w) + int'(bits[8])) % 2) != 0);
`endif
        bits.delete();
      end
    end
    nv = exp_valid;
    if (comp) begin
      if (!exp_valid || rdy) begin
        sb_q.push_back({pe, w});
        nv = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      nv = 1'b0;
    end
    no = drop ? 1'b1 : (clr ? 1'b0 : exp_ovr);
    @(posedge clk);
    exp_valid = nv;
    exp_ovr   = no;
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Send a full frame. rdy_last is out_ready during the final bit. par is the
  // parity bit, used only when the frame carries one.
  task automatic send_word(input logic [7:0] w, input logic rdy,
                           input logic rdy_last, input logic par);
    logic b;
    for (int i = 0; i < FRAME; i++) begin
      b = (i < 8) ? w[i] : par;
      cycle(b, 1'b1, 1'b0, (i == FRAME - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bits.delete();
    sb_q.delete();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_data_out", {1'b0, data_out}, 9'h000);
    chk("rst_out_valid", {8'b0, out_valid}, 9'h000);
    chk("rst_overrun", {8'b0, overrun}, 9'h000);
`ifdef DESER_PARITY_EN
    chk("rst_parity_err", {8'b0, parity_err}, 9'h000);
`endif
    rst = 1'b1;
  endtask

  // Monitor: compares against the model every cycle. While a word is presented,
  // it checks that word against the scoreboard head and pops it on acceptance.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("out_valid", {8'b0, out_valid}, {8'b0, exp_valid});
      chk("overrun", {8'b0, overrun}, {8'b0, exp_ovr});
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: out_valid=1 data_out=0x%0h with no expected word at %0t",
                   data_out, $time);
        end else begin
`ifdef DESER_PARITY_EN
          chk("data_out", {parity_err, data_out}, sb_q[0]);
`else
          chk("data_out", {1'b0, data_out}, sb_q[0]);
`endif
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  logic [7:0] w81;

  initial begin
    rst = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0;
    out_ready = 1'b0; clr_ovr = 1'b0;
    do_reset();
    mon_on = 1'b1;

    // 0xA5: output one clock after the last bit, then consumed.
    send_word(8'hA5, 1'b1, 1'b1, ^8'hA5);
    chk("a5_data", {1'b0, data_out}, 9'h0A5);
    chk("a5_valid", {8'b0, out_valid}, 9'h001);
    idle(1, 1'b1);
    chk("a5_valid_clr", {8'b0, out_valid}, 9'h000);

    // 0x3C held, 0xFF dropped, then overrun cleared.
    send_word(8'h3C, 1'b0, 1'b0, ^8'h3C);
    send_word(8'hFF, 1'b0, 1'b0, ^8'hFF);
    chk("ovr_data_held", {1'b0, data_out}, 9'h03C);
    chk("ovr_set", {8'b0, overrun}, 9'h001);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", {8'b0, overrun}, 9'h000);
    idle(1, 1'b1);

    // Accept 0x12 in the same cycle that 0x34 completes.
    send_word(8'h12, 1'b0, 1'b0, ^8'h12);
    send_word(8'h34, 1'b0, 1'b1, ^8'h34);
    chk("simul_data", {1'b0, data_out}, 9'h034);
    chk("simul_valid", {8'b0, out_valid}, 9'h001);
    chk("simul_no_ovr", {8'b0, overrun}, 9'h000);
    idle(1, 1'b1);

    // A partial frame, then sync with a qualified bit as bit 0 of 0x81.
    w81 = 8'h81;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(w81[0], 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) cycle(w81[i], 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 8; i < FRAME; i++) cycle(^w81, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sync_data", {1'b0, data_out}, 9'h081);
    idle(1, 1'b1);

    // Reset after 5 bits, then a clean frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_word(8'h5A, 1'b1, 1'b1, ^8'h5A);
    chk("post_rst_data", {1'b0, data_out}, 9'h05A);
    idle(1, 1'b1);

`ifdef DESER_PARITY_EN
    send_word(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_bad_err", {8'b0, parity_err}, 9'h001);
    chk("par_bad_data", {1'b0, data_out}, 9'h007);
    send_word(8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_good_err", {8'b0, parity_err}, 9'h000);
    idle(1, 1'b1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end

    idle(3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    mon_on = 1'b0;
    chk("sb_drained", 9'(sb_q.size()), 9'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
